// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester (fetch/data) round-robin arbiter onto one memory port, one read outstanding.
// Ports:
//   clk, rst                      - clock and async active-high reset
//   ifReq/ifAddr/ifGnt            - fetch request, address, grant
//   ifRdValid/ifRdData            - fetch read return
//   dReq/dWe/dAddr/dWrData/dGnt   - data request, write strobe, address, store data, grant
//   dRdValid/dRdData              - data read return
//   memReq/memWe/memAddr/memWrData/memReady - memory request channel
//   memRdValid/memRdData          - memory read return
//   errSpurious                   - sticky: read data returned with nothing outstanding
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifGnt,
    output logic                  ifRdValid,
    output logic [DATA_WIDTH-1:0] ifRdData,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWrData,
    output logic                  dGnt,
    output logic                  dRdValid,
    output logic [DATA_WIDTH-1:0] dRdData,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWrData,
    input  logic                  memReady,
    input  logic                  memRdValid,
    input  logic [DATA_WIDTH-1:0] memRdData,
    output logic                  errSpurious
);
    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;
    state_t r_state, w_next;
    logic r_last_d, r_hold_valid, r_hold_d, r_err;
    logic w_sel_d, w_req, w_acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b1;
            r_hold_valid <= 1'b0;
            r_hold_d     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            if (w_acc) r_last_d <= w_sel_d;
            // a stalled request keeps its selection so the port stays stable
            r_hold_valid <= w_req & ~memReady;
            r_hold_d     <= w_sel_d;
            r_err        <= r_err | ((r_state == IDLE) & memRdValid);
        end
    end
    always_comb begin
        w_sel_d     = r_hold_valid ? r_hold_d : (ifReq & dReq) ? ~r_last_d : dReq;
        // outputs are forced low while reset is held, even with requests pending
        w_req       = ~rst & (r_state == IDLE) & (ifReq | dReq);
        w_acc       = w_req & memReady;
        memReq      = w_req;
        memWe       = w_req & w_sel_d & dWe;
        memAddr     = ~w_req ? '0 : w_sel_d ? dAddr : ifAddr;
        memWrData   = (w_req & w_sel_d) ? dWrData : '0;
        ifGnt       = w_acc & ~w_sel_d;
        dGnt        = w_acc & w_sel_d;
        ifRdValid   = ~rst & (r_state == WAIT_IF) & memRdValid;
        dRdValid    = ~rst & (r_state == WAIT_D) & memRdValid;
        ifRdData    = ifRdValid ? memRdData : '0;
        dRdData     = dRdValid ? memRdData : '0;
        errSpurious = r_err;
        w_next      = (r_state == IDLE) ? (ifGnt ? WAIT_IF : (dGnt & ~dWe) ? WAIT_D : IDLE)
                                        : (memRdValid ? IDLE : r_state);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a per-cycle behavioural model of the arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq = 0, dReq = 0, dWe = 0, memReady = 0, memRdValid = 0;
    logic [31:0] ifAddr = 0, dAddr = 0, dWrData = 0, memRdData = 0;
    logic        ifGnt, ifRdValid, dGnt, dRdValid, memReq, memWe, errSpurious;
    logic [31:0] ifRdData, dRdData, memAddr, memWrData;

    int errors = 0, checks = 0;
    // model: owner of outstanding read (0 none, 1 fetch, 2 data), last winner, stalled choice (0 none, 1 fetch, 2 data)
    int m_out = 0, m_held = 0;
    bit m_last_d = 1, m_err = 0;
    // DUT snapshot taken at the falling edge
    logic        s_ifGnt, s_dGnt, s_ifRdValid, s_dRdValid, s_memReq, s_memWe, s_err;
    logic [31:0] s_ifRdData, s_dRdData, s_memAddr, s_memWrData;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRdValid(ifRdValid), .ifRdData(ifRdData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWrData(dWrData), .dGnt(dGnt),
        .dRdValid(dRdValid), .dRdData(dRdData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
        .memReady(memReady), .memRdValid(memRdValid), .memRdData(memRdData),
        .errSpurious(errSpurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle: compare everything against the model, then advance the model
    task automatic tick();
        bit idle, req, pick_d, e_ig, e_dg, e_iv, e_dv, e_we;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        idle   = (m_out == 0);
        req    = !rst && idle && (ifReq || dReq);
        pick_d = (m_held != 0) ? (m_held == 2) : (ifReq && dReq) ? !m_last_d : dReq;
        e_addr = req ? (pick_d ? dAddr : ifAddr) : 32'h0;
        e_wd   = (req && pick_d) ? dWrData : 32'h0;
        e_we   = req && pick_d && dWe;
        e_ig   = req && memReady && !pick_d;
        e_dg   = req && memReady && pick_d;
        e_iv   = !rst && (m_out == 1) && memRdValid;
        e_dv   = !rst && (m_out == 2) && memRdValid;
        {s_ifGnt, s_dGnt, s_ifRdValid, s_dRdValid, s_memReq, s_memWe, s_err} =
            {ifGnt, dGnt, ifRdValid, dRdValid, memReq, memWe, errSpurious};
        {s_ifRdData, s_dRdData, s_memAddr, s_memWrData} = {ifRdData, dRdData, memAddr, memWrData};
        chk("m_memReq", 64'(s_memReq), 64'(req));
        chk("m_memAddr", 64'(s_memAddr), 64'(e_addr));
        chk("m_memWe", 64'(s_memWe), 64'(e_we));
        chk("m_memWrData", 64'(s_memWrData), 64'(e_wd));
        chk("m_ifGnt", 64'(s_ifGnt), 64'(e_ig));
        chk("m_dGnt", 64'(s_dGnt), 64'(e_dg));
        chk("m_ifRdValid", 64'(s_ifRdValid), 64'(e_iv));
        chk("m_dRdValid", 64'(s_dRdValid), 64'(e_dv));
        chk("m_ifRdData", 64'(s_ifRdData), 64'(e_iv ? memRdData : 32'h0));
        chk("m_dRdData", 64'(s_dRdData), 64'(e_dv ? memRdData : 32'h0));
        chk("m_errSpurious", 64'(s_err), 64'(!rst && m_err));
        @(posedge clk);
        if (rst) begin
            m_out = 0; m_last_d = 1; m_held = 0; m_err = 0;
        end else begin
            if (idle && memRdValid) m_err = 1;
            if (!idle && memRdValid) m_out = 0;
            else if (e_ig) begin m_out = 1; m_last_d = 0; m_held = 0; end
            else if (e_dg) begin m_out = dWe ? 0 : 2; m_last_d = 1; m_held = 0; end
            else m_held = req ? (pick_d ? 2 : 1) : 0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifReq = 1; ifAddr = 32'h100;
        tick();
        chk("rst_memReq", 64'(s_memReq), 64'd0);
        tick();
        chk("rst_memAddr", 64'(s_memAddr), 64'd0);
        rst = 0;
        // tie after reset: fetch first, data two cycles later
        dReq = 1; dWe = 0; dAddr = 32'h200; memReady = 1;
        tick();
        chk("tie_ifGnt", 64'(s_ifGnt), 64'd1);
        chk("tie_dGnt0", 64'(s_dGnt), 64'd0);
        ifReq = 0; memRdValid = 1; memRdData = 32'h1111_1111;
        tick();
        chk("tie_ifRdValid", 64'(s_ifRdValid), 64'd1);
        chk("tie_ifRdData", 64'(s_ifRdData), 64'h1111_1111);
        chk("tie_noIssueReturn", 64'(s_memReq), 64'd0);
        memRdValid = 0;
        tick();
        chk("tie_dGnt", 64'(s_dGnt), 64'd1);
        chk("tie_dAddr", 64'(s_memAddr), 64'h200);
        dReq = 0; memRdValid = 1; memRdData = 32'h2222_2222;
        tick();
        chk("tie_dRdValid", 64'(s_dRdValid), 64'd1);
        chk("tie_dRdData", 64'(s_dRdData), 64'h2222_2222);
        chk("tie_ifRdDataZero", 64'(s_ifRdData), 64'd0);
        memRdValid = 0;
        // back-to-back writes
        dReq = 1; dWe = 1; dAddr = 32'h10; dWrData = 32'hA5A5;
        tick();
        chk("wr0_dGnt", 64'(s_dGnt), 64'd1);
        chk("wr0_memWe", 64'(s_memWe), 64'd1);
        chk("wr0_data", 64'(s_memWrData), 64'hA5A5);
        dAddr = 32'h14; dWrData = 32'h5A5A;
        tick();
        chk("wr1_dGnt", 64'(s_dGnt), 64'd1);
        chk("wr1_addr", 64'(s_memAddr), 64'h14);
        chk("wr1_data", 64'(s_memWrData), 64'h5A5A);
        chk("wr1_noRd", 64'(s_dRdValid), 64'd0);
        dReq = 0; dWe = 0;
        // variable latency fetch: return 5 cycles after the grant
        ifReq = 1; ifAddr = 32'h30;
        tick();
        chk("lat_ifGnt", 64'(s_ifGnt), 64'd1);
        ifReq = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lat_waitReq", 64'(s_memReq), 64'd0);
        end
        memRdValid = 1; memRdData = 32'hDEAD_BEEF;
        tick();
        chk("lat_ifRdValid", 64'(s_ifRdValid), 64'd1);
        chk("lat_ifRdData", 64'(s_ifRdData), 64'hDEAD_BEEF);
        memRdValid = 0;
        tick();
        chk("lat_pulseEnd", 64'(s_ifRdValid), 64'd0);
        // backpressure: fetch stalls, data arriving mid-stall must not steal the port
        ifReq = 1; ifAddr = 32'h40; memReady = 0;
        tick();
        chk("bp_req", 64'(s_memReq), 64'd1);
        chk("bp_addr0", 64'(s_memAddr), 64'h40);
        dReq = 1; dWe = 1; dAddr = 32'h80; dWrData = 32'h77;
        tick();
        chk("bp_addr1", 64'(s_memAddr), 64'h40);
        chk("bp_we1", 64'(s_memWe), 64'd0);
        tick();
        chk("bp_addr2", 64'(s_memAddr), 64'h40);
        memReady = 1;
        tick();
        chk("bp_ifGnt", 64'(s_ifGnt), 64'd1);
        chk("bp_dGnt", 64'(s_dGnt), 64'd0);
        ifReq = 0; memRdValid = 1; memRdData = 32'h3333_3333;
        tick();
        chk("bp_ifRdValid", 64'(s_ifRdValid), 64'd1);
        memRdValid = 0;
        tick();
        chk("bp_dWrGnt", 64'(s_dGnt), 64'd1);
        chk("bp_dWrAddr", 64'(s_memAddr), 64'h80);
        dReq = 0; dWe = 0;
        // spurious return in IDLE, then reset abandoning an outstanding data read
        memRdValid = 1; memRdData = 32'h99;
        tick();
        chk("sp_noValid", 64'(s_dRdValid | s_ifRdValid), 64'd0);
        memRdValid = 0;
        tick();
        chk("sp_err", 64'(s_err), 64'd1);
        tick();
        chk("sp_errSticky", 64'(s_err), 64'd1);
        dReq = 1; dAddr = 32'h90;
        tick();
        chk("sp_dGnt", 64'(s_dGnt), 64'd1);
        dReq = 0; rst = 1;
        tick();
        chk("rs_err", 64'(s_err), 64'd0);
        rst = 0;
        tick();
        chk("rs_errAfter", 64'(s_err), 64'd0);
        memRdValid = 1; memRdData = 32'h55;
        tick();
        chk("rs_lateNoValid", 64'(s_dRdValid), 64'd0);
        memRdValid = 0;
        tick();
        chk("rs_lateErr", 64'(s_err), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte address width, shared by both requesters and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ifReq  in  1  instruction-fetch read request; held until ifGnt.
REQ-006 ifAddr  in  ADDR_WIDTH  fetch address; stable while ifReq is high.
REQ-007 ifGnt  out  1  fetch request accepted by memory this cycle.
REQ-008 ifRdValid  out  1  ifRdData valid; one-cycle pulse.
REQ-009 ifRdData  out  DATA_WIDTH  fetched instruction word.
REQ-010 dReq  in  1  data request; held until dGnt.
REQ-011 dWe  in  1  data request is a write (1) or a read (0).
REQ-012 dAddr  in  ADDR_WIDTH  data address.
REQ-013 dWrData  in  DATA_WIDTH  store data.
REQ-014 dGnt  out  1  data request accepted by memory this cycle.
REQ-015 dRdValid  out  1  dRdData valid; one-cycle pulse.
REQ-016 dRdData  out  DATA_WIDTH  load data.
REQ-017 memReq, memWe  out  1 each  memory request and write strobe.
REQ-018 memAddr, memWrData  out  ADDR_WIDTH, DATA_WIDTH  memory address and write data.
REQ-019 memReady  in  1  memory accepts a request when memReq and memReady are both high.
REQ-020 memRdValid, memRdData  in  1, DATA_WIDTH  read return; latency is variable, at least 1 cycle.
REQ-021 errSpurious  out  1  sticky flag: memRdValid arrived with no read outstanding.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT_IF and WAIT_D, with at most one read outstanding.
REQ-023 In IDLE, when either request is pending: memReq=1 and the memory port is driven from the selected requester. Otherwise memReq=0 and memAddr, memWrData and memWe are 0.
REQ-024 Selection when only one request is pending: that requester.
REQ-025 Selection when both requests are pending: the requester not granted most recently (round-robin on lastGnt).
REQ-026 Grant: ifGnt or dGnt SHALL assert combinationally in the cycle that memReq and memReady are high for that requester. Never both in one cycle. Never outside IDLE.
REQ-027 lastGnt SHALL update on every grant.
REQ-028 Accepted fetch: next state WAIT_IF.
REQ-029 Accepted data read: next state WAIT_D.
REQ-030 Accepted data write: remain in IDLE; no dRdValid. Back-to-back requests are allowed on consecutive cycles.
REQ-031 In WAIT_IF or WAIT_D, memReq SHALL be 0. On memRdValid: route memRdData to the matching xRdData, pulse the matching xRdValid the same cycle (combinational), and return to IDLE on the next edge.
REQ-032 Return-cycle issue: a new request SHALL NOT be issued in the return cycle. Minimum read-to-read spacing is 2 cycles.
REQ-033 Idle read data: ifRdData and dRdData SHALL be 0 when their valid is low.
REQ-034 memReady low in IDLE: hold the selection unchanged (no re-arbitration) until accepted, so memAddr, memWe and memWrData stay stable.
REQ-035 memRdValid in IDLE: set errSpurious, ignore the data, no state change.
REQ-036 errSpurious SHALL clear only on reset.
REQ-037 A requester dropping its request before grant is a protocol violation; behaviour is undefined.

Reset
REQ-038 On rst: state=IDLE, lastGnt=data (so fetch wins the first tie), held selection cleared, errSpurious=0.
REQ-039 While rst is high: all outputs 0.
REQ-040 Reset asserted during WAIT_IF or WAIT_D SHALL abandon the outstanding read. A later memRdValid is then flagged by errSpurious.

Verification
REQ-041 Tie after reset: ifReq=dReq=1 (dWe=0), memReady=1, read latency 1 -> ifGnt cycle 0, ifRdValid cycle 1, dGnt cycle 2, dRdValid cycle 3.
REQ-042 Back-to-back writes: dReq=1, dWe=1, addrs 0x10, 0x14, memReady=1 -> dGnt on 2 consecutive cycles; memWe=1, memWrData matches dWrData; dRdValid never asserts.
REQ-043 Backpressure: memReady=0 for 3 cycles with ifAddr=0x40 -> memReq=1 and memAddr=0x40 held stable. A dReq arriving mid-stall does not steal the port. ifGnt in the cycle memReady rises.
REQ-044 Variable latency: memRdValid 5 cycles after a fetch grant, data 0xDEADBEEF -> ifRdValid=1, ifRdData=0xDEADBEEF in that cycle only; memReq=0 throughout the wait.
REQ-045 Spurious return and reset: memRdValid in IDLE -> errSpurious=1 and stays 1. Then rst in WAIT_D -> state IDLE, errSpurious=0, and a late memRdValid sets errSpurious=1 again.
